// File: rtl/oled_line_formatter.sv
// oled_line_formatter: 16-bit value to a 16-char ASCII OLED row, decimal left, hex right.
// Double-dabble conversion runs one bit per clock; LINE updates atomically on completion.
module oled_line_formatter #(
  parameter logic [7:0] LABEL_DEC = 8'h44,
  parameter logic [7:0] LABEL_HEX = 8'h48
) (
  input  logic         GCLK,
  input  logic         RESETN,
  input  logic         START,
  input  logic [15:0]  VALUE,
  output logic         BUSY,
  output logic         DONE,
  output logic [127:0] LINE
);
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t state, state_nx;
  logic [15:0] sh, hex_hold;
  logic [19:0] bcd, bcd_adj;
  logic [3:0] cnt;
  logic [127:0] line_nx;
  logic seen;
  logic [3:0] nib;
  assign BUSY = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (START ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == 4'd15 ? FORMAT : SHIFT) : IDLE;
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Leading decimal zeros blank to spaces; the units digit always shows.
  always_comb begin
    line_nx = {LABEL_DEC, 8'h3A, 40'h2020202020, 8'h20, LABEL_HEX, 8'h3A, 32'h0, 16'h2020};
    seen = 1'b0;
    nib = 4'h0;
    for (int i = 4; i >= 0; i--) begin
      seen = seen | (bcd[4*i +: 4] != 4'h0) | (i == 0);
      line_nx[127 - 8*(6 - i) -: 8] = seen ? {4'h3, bcd[4*i +: 4]} : 8'h20;
    end
    for (int j = 0; j < 4; j++) begin
      nib = hex_hold[15 - 4*j -: 4];
      line_nx[127 - 8*(10 + j) -: 8] = {4'h0, nib} + (nib < 4'd10 ? 8'h30 : 8'h37);
    end
  end
  always_ff @(posedge GCLK) begin
    if (!RESETN) begin
      state <= IDLE;
      sh <= '0;
      hex_hold <= '0;
      bcd <= '0;
      cnt <= '0;
      DONE <= 1'b0;
      LINE <= {16{8'h20}};
    end else begin
      state <= state_nx;
      DONE <= state == FORMAT;
      if (state == IDLE && START) begin
        sh <= VALUE;
        hex_hold <= VALUE;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        {bcd, sh} <= {bcd_adj[18:0], sh, 1'b0};
        cnt <= cnt + 4'd1;
      end
      if (state == FORMAT) LINE <= line_nx;
    end
  end
endmodule

// File: tb/tb_oled_line_formatter.sv
// tb_oled_line_formatter: directed vector table plus hand sequences for back-to-back, ignored START and reset abort.
module tb_oled_line_formatter;
  logic GCLK = 1'b0;
  logic RESETN, START;
  logic [15:0] VALUE;
  logic BUSY, DONE, busy2, done2;
  logic [127:0] LINE, line2, last;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] SPACES = {16{8'h20}};
  typedef struct {
    logic [15:0] value;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[7];
  always #5 GCLK = ~GCLK;
  oled_line_formatter dut (
    .GCLK(GCLK), .RESETN(RESETN), .START(START), .VALUE(VALUE),
    .BUSY(BUSY), .DONE(DONE), .LINE(LINE)
  );
  oled_line_formatter #(.LABEL_DEC(8'h58), .LABEL_HEX(8'h59)) dut2 (
    .GCLK(GCLK), .RESETN(RESETN), .START(START), .VALUE(VALUE),
    .BUSY(busy2), .DONE(done2), .LINE(line2)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h (\"%s\") expected %h (\"%s\")", name, act, act, exp, exp);
    end
  endtask
  task automatic run(input logic [15:0] v, input logic [127:0] exp, input logic [127:0] prev);
    int n, bc;
    logic held;
    held = 1'b1;
    bc = 0;
    @(negedge GCLK);
    START = 1'b1;
    VALUE = v;
    @(negedge GCLK);
    START = 1'b0;
    VALUE = 16'h5A5A;
    n = 1;
    while (!DONE && n < 40) begin
      if (BUSY) bc++;
      if (LINE !== prev) held = 1'b0;
      @(negedge GCLK);
      n++;
    end
    chk("done_latency", n, 18);
    chk("busy_cycles", bc, 17);
    chk("busy_low_at_done", BUSY, 0);
    chk("line", LINE, exp);
    chk("line_held", held, 1);
    @(negedge GCLK);
    chk("done_single", DONE, 0);
    chk("line_keep", LINE, exp);
  endtask
  initial begin
    int idx;
    logic flag;
    vecs[0] = '{16'd0,     "D:    0 H:0000  "};
    vecs[1] = '{16'hFFFF,  "D:65535 H:FFFF  "};
    vecs[2] = '{16'd1234,  "D: 1234 H:04D2  "};
    vecs[3] = '{16'd10,    "D:   10 H:000A  "};
    vecs[4] = '{16'd9,     "D:    9 H:0009  "};
    vecs[5] = '{16'hA000,  "D:40960 H:A000  "};
    vecs[6] = '{16'd99999 % 65536, "D:34463 H:869F  "};
    RESETN = 1'b0;
    START = 1'b0;
    VALUE = 16'd0;
    repeat (3) @(negedge GCLK);
    chk("reset_line", LINE, SPACES);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    RESETN = 1'b1;
    repeat (5) @(negedge GCLK);
    chk("idle_busy", BUSY, 0);
    chk("idle_line", LINE, SPACES);
    last = SPACES;
    for (int i = 0; i < 7; i++) begin
      run(vecs[i].value, vecs[i].exp, last);
      last = vecs[i].exp;
    end
    // START held high: only IDLE-cycle VALUEs are taken, DONE cycles restart.
    @(negedge GCLK);
    START = 1'b1;
    VALUE = 16'd100;
    flag = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge GCLK);
      if (DONE) flag = 1'b1;
      VALUE = 16'(5000 + k);
    end
    @(negedge GCLK);
    chk("b2b_done1", DONE, 1);
    chk("b2b_line1", LINE, "D:  100 H:0064  ");
    VALUE = 16'd777;
    for (int k = 1; k <= 17; k++) begin
      @(negedge GCLK);
      if (DONE) flag = 1'b1;
      VALUE = 16'(9000 + k);
    end
    @(negedge GCLK);
    chk("b2b_done2", DONE, 1);
    chk("b2b_line2", LINE, "D:  777 H:0309  ");
    chk("b2b_no_early_done", flag, 0);
    START = 1'b0;
    @(negedge GCLK);
    chk("b2b_stop_done", DONE, 0);
    chk("b2b_stop_busy", BUSY, 0);
    // START pulse in the middle of a conversion is dropped.
    START = 1'b1;
    VALUE = 16'd10;
    @(negedge GCLK);
    START = 1'b0;
    repeat (4) @(negedge GCLK);
    START = 1'b1;
    VALUE = 16'd999;
    @(negedge GCLK);
    START = 1'b0;
    idx = 6;
    while (!DONE && idx < 40) begin
      @(negedge GCLK);
      idx++;
    end
    chk("mid_start_latency", idx, 18);
    chk("mid_start_line", LINE, "D:   10 H:000A  ");
    flag = 1'b0;
    repeat (25) begin
      @(negedge GCLK);
      if (DONE || BUSY) flag = 1'b1;
    end
    chk("mid_start_no_second", flag, 0);
    // Reset at T+8 aborts the conversion and blanks LINE.
    START = 1'b1;
    VALUE = 16'd40000;
    @(negedge GCLK);
    START = 1'b0;
    repeat (7) @(negedge GCLK);
    RESETN = 1'b0;
    @(negedge GCLK);
    RESETN = 1'b1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_line", LINE, SPACES);
    flag = 1'b0;
    repeat (25) begin
      @(negedge GCLK);
      if (DONE || BUSY) flag = 1'b1;
    end
    chk("abort_no_done", flag, 0);
    run(16'd40000, "D:40000 H:9C40  ", SPACES);
    run(16'd255, "D:  255 H:00FF  ", "D:40000 H:9C40  ");
    chk("param_labels", line2, "X:  255 Y:00FF  ");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
